// File: rtl/ticket_pkg.sv
// rtl/ticket_pkg.sv - shared state type, coin values and pricing helpers for the ticket vending controller
package ticket_pkg;

    typedef enum logic [2:0] {
        ST_SELECT   = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    localparam logic [6:0] COIN1_VAL  = 7'd1;
    localparam logic [6:0] COIN5_VAL  = 7'd5;
    localparam logic [6:0] COIN10_VAL = 7'd10;
    localparam logic [6:0] COIN50_VAL = 7'd50;
    localparam logic [8:0] MONEY_MAX  = 9'd255;
    localparam int         TIMER_W    = 16;

    function automatic logic [3:0] price(input logic [1:0] ticket_type, input logic [1:0] ticket_count);
        return {2'b00, ticket_type} * {2'b00, ticket_count};
    endfunction

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd1 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/ticket_sell_ctrl_if.sv
// rtl/ticket_sell_ctrl_if.sv - coin/button inputs and display-stage outputs of the ticket vending controller
interface ticket_sell_ctrl_if;

    logic       coin1;
    logic       coin5;
    logic       coin10;
    logic       coin50;
    logic       btn_type;
    logic       btn_count;
    logic       btn_confirm;
    logic       btn_cancel;
    logic [7:0] money;
    logic [1:0] ticketType;
    logic [1:0] ticketCount;
    logic [7:0] moneyReturn;
    logic       ticket_out;
    logic       coin_reject;
    logic       busy;

    modport master (
        output coin1, coin5, coin10, coin50,
        output btn_type, btn_count, btn_confirm, btn_cancel,
        input  money, ticketType, ticketCount, moneyReturn,
        input  ticket_out, coin_reject, busy
    );

    modport slave (
        input  coin1, coin5, coin10, coin50,
        input  btn_type, btn_count, btn_confirm, btn_cancel,
        output money, ticketType, ticketCount, moneyReturn,
        output ticket_out, coin_reject, busy
    );

endinterface

// File: rtl/ticket_hold_timer.sv
// rtl/ticket_hold_timer.sv - loadable saturating down-counter; done while the count sits at zero
module ticket_hold_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ticket_sell_ctrl.sv
// rtl/ticket_sell_ctrl.sv - ticket vending FSM; define TICKET_TIMEOUT_EN to refund automatically after an idle PAY period
module ticket_sell_ctrl
    import ticket_pkg::*;
#(
    parameter int HOLD_CYCLES    = 100,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               rst,
    ticket_sell_ctrl_if.slave  io_sell
);

    localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t       r_state, w_state_nxt;
    logic [7:0]   r_money, w_money_nxt;
    logic [1:0]   r_type, w_type_nxt;
    logic [1:0]   r_count, w_count_nxt;
    logic [7:0]   r_return, w_return_nxt;
    logic         r_ticket, w_ticket_nxt;
    logic         r_reject, w_reject_nxt;
    logic         r_busy, w_busy_nxt;

    logic [6:0]   w_coin_sum;
    logic         w_coin_any;
    logic [8:0]   w_money_sum;
    logic         w_overflow;
    logic [3:0]   w_price;
    logic         w_activity;
    logic         w_timeout;

    logic                w_tmr_load;
    logic [TIMER_W-1:0]  w_tmr_load_val;
    logic                w_tmr_en;
    logic                w_tmr_done;

    assign w_coin_sum  = (io_sell.coin1  ? COIN1_VAL  : 7'd0)
                       + (io_sell.coin5  ? COIN5_VAL  : 7'd0)
                       + (io_sell.coin10 ? COIN10_VAL : 7'd0)
                       + (io_sell.coin50 ? COIN50_VAL : 7'd0);
    assign w_coin_any  = (w_coin_sum != 7'd0);
    assign w_money_sum = {1'b0, r_money} + {2'b00, w_coin_sum};
    assign w_overflow  = (w_money_sum > MONEY_MAX);
    assign w_price     = price(r_type, r_count);
    assign w_activity  = w_coin_any | io_sell.btn_type | io_sell.btn_count
                       | io_sell.btn_confirm | io_sell.btn_cancel;

`ifdef TICKET_TIMEOUT_EN
    assign w_timeout = (r_state == ST_PAY) && !w_activity && w_tmr_done;
`else
    assign w_timeout = 1'b0;
`endif

    // One timer paces ticket pulses, holds change/refund and measures PAY idle time.
    ticket_hold_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_money_nxt    = r_money;
        w_type_nxt     = r_type;
        w_count_nxt    = r_count;
        w_return_nxt   = r_return;
        w_ticket_nxt   = 1'b0;
        w_reject_nxt   = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = HOLD_LOAD;
        w_tmr_en       = 1'b0;

        case (r_state)
            ST_SELECT: begin
                if (io_sell.btn_type)  w_type_nxt  = next_sel(r_type);
                if (io_sell.btn_count) w_count_nxt = next_sel(r_count);
                if (w_coin_any) begin
                    w_money_nxt    = w_money_sum[7:0];
                    w_state_nxt    = ST_PAY;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TIMEOUT_LOAD;
                end
            end
            ST_PAY: begin
                w_tmr_en       = 1'b1;
                w_tmr_load     = w_activity;
                w_tmr_load_val = TIMEOUT_LOAD;
                if (io_sell.btn_cancel || w_timeout) begin
                    w_return_nxt   = r_money;
                    w_money_nxt    = 8'd0;
                    w_reject_nxt   = w_coin_any;
                    w_state_nxt    = ST_REFUND;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = HOLD_LOAD;
                end else if (io_sell.btn_confirm && ({4'b0000, w_price} <= r_money)) begin
                    // Coins arriving with an accepted confirm are turned away so the paid sum stays fixed.
                    w_reject_nxt   = w_coin_any;
                    w_state_nxt    = ST_DISPENSE;
                    w_ticket_nxt   = 1'b1;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = {{(TIMER_W-3){1'b0}}, ({r_count, 1'b0} - 3'd1)};
                end else if (w_coin_any) begin
                    if (w_overflow) w_reject_nxt = 1'b1;
                    else            w_money_nxt  = w_money_sum[7:0];
                end
            end
            ST_DISPENSE: begin
                w_reject_nxt = w_coin_any;
                if (w_tmr_done) begin
                    w_return_nxt = r_money - {4'b0000, w_price};
                    w_money_nxt  = 8'd0;
                    w_state_nxt  = ST_CHANGE;
                    w_tmr_load   = 1'b1;
                end else begin
                    w_tmr_en     = 1'b1;
                    w_ticket_nxt = ~r_ticket;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                w_reject_nxt = w_coin_any;
                if (w_tmr_done) begin
                    w_return_nxt = 8'd0;
                    w_type_nxt   = 2'd1;
                    w_count_nxt  = 2'd1;
                    w_state_nxt  = ST_SELECT;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SELECT;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE)
                  || (w_state_nxt == ST_REFUND);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_SELECT;
            r_money  <= 8'd0;
            r_type   <= 2'd1;
            r_count  <= 2'd1;
            r_return <= 8'd0;
            r_ticket <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_money  <= w_money_nxt;
            r_type   <= w_type_nxt;
            r_count  <= w_count_nxt;
            r_return <= w_return_nxt;
            r_ticket <= w_ticket_nxt;
            r_reject <= w_reject_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign io_sell.money       = r_money;
    assign io_sell.ticketType  = r_type;
    assign io_sell.ticketCount = r_count;
    assign io_sell.moneyReturn = r_return;
    assign io_sell.ticket_out  = r_ticket;
    assign io_sell.coin_reject = r_reject;
    assign io_sell.busy        = r_busy;

endmodule
